cl_camera_sim: RTL

- Camera Link transmitter model: generates cl_fval, cl_lval and an 80-bit cl_data stream on cl_clk, with the same framing the capture path consumes.
- Used as an on-FPGA loopback source and as a bench stimulus for the capture block.
- Emits a requested number of frames with programmable line and blanking geometry.
- Data words encode frame, line and clock indices so the receiver side can check them end to end.

---
 rtl/cl_camera_sim.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/cl_camera_sim.sv
// Camera Link transmitter model: emits framed fval/lval/data with frame/line/clk-indexed words.
// Define CL_SIM_LFSR_EN to replace the low-word counter with a 32-bit LFSR.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | waiting for start, outputs low
// S_SETUP  | fval high, lval low, before first line of frame
// S_LINE   | fval and lval high, data words emitted
// S_HBLANK | fval high, lval low, between lines
// S_VBLANK | fval low after a frame, run ends or next frame
module cl_camera_sim #(
    parameter int N_LINE   = 4,
    parameter int N_CLK    = 8,
    parameter int H_BLANK  = 3,
    parameter int V_BLANK  = 5,
    parameter int FV_SETUP = 2
) (
    input  logic        reset,
    input  logic        cl_clk,
    input  logic        start,
    input  logic [19:0] n_frame_req,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        cl_fval,
    output logic        cl_lval,
    output logic [79:0] cl_data,
    output logic [19:0] frame_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_LINE,
        S_HBLANK,
        S_VBLANK
    } state_t;

    localparam logic [31:0] SETUP_M1  = 32'(FV_SETUP - 1);
    localparam logic [31:0] NCLK_M1   = 32'(N_CLK - 1);
    localparam logic [31:0] HBLANK_M1 = 32'(H_BLANK - 1);
    localparam logic [31:0] VBLANK_M1 = 32'(V_BLANK - 1);
    localparam logic [15:0] LAST_LINE = 16'(N_LINE - 1);

`ifdef CL_SIM_LFSR_EN
    localparam logic [31:0] WORD_INIT = 32'h1;
`else
    localparam logic [31:0] WORD_INIT = 32'h0;
`endif

    state_t      state_q, state_d;
    logic [31:0] tmr_q, tmr_d;
    logic [15:0] line_q, line_d;
    logic [15:0] clk_idx_q, clk_idx_d;
    logic [31:0] word_q, word_d;
    logic [31:0] word_nxt;
    logic [19:0] req_q, req_d;
    logic [19:0] frame_cnt_q, frame_cnt_d;
    logic        abort_q, abort_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fval_q, fval_d;
    logic        lval_q, lval_d;
    logic [79:0] data_q, data_d;

    // Fibonacci LFSR taps 32,22,2,1 shifting toward the MSB.
`ifdef CL_SIM_LFSR_EN
    assign word_nxt = {word_q[30:0], word_q[31] ^ word_q[21] ^ word_q[1] ^ word_q[0]};
`else
    assign word_nxt = word_q + 32'd1;
`endif

    always_comb begin
        state_d     = state_q;
        tmr_d       = tmr_q;
        line_d      = line_q;
        clk_idx_d   = clk_idx_q;
        word_d      = word_q;
        req_d       = req_q;
        frame_cnt_d = frame_cnt_q;
        abort_d     = abort_q | (abort && (state_q != S_IDLE));
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    frame_cnt_d = 20'd0;
                    abort_d     = 1'b0;
                    word_d      = WORD_INIT;
                    if (n_frame_req != 20'd0) begin
                        req_d   = n_frame_req;
                        state_d = S_SETUP;
                        tmr_d   = SETUP_M1;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_SETUP: begin
                if (tmr_q == 32'd0) begin
                    state_d   = S_LINE;
                    tmr_d     = NCLK_M1;
                    line_d    = 16'd0;
                    clk_idx_d = 16'd0;
                end else begin
                    tmr_d = tmr_q - 32'd1;
                end
            end
            S_LINE: begin
                word_d = word_nxt;
                if (tmr_q == 32'd0) begin
                    if (line_q == LAST_LINE) begin
                        state_d     = S_VBLANK;
                        tmr_d       = VBLANK_M1;
                        frame_cnt_d = frame_cnt_q + 20'd1;
                    end else begin
                        state_d = S_HBLANK;
                        tmr_d   = HBLANK_M1;
                    end
                end else begin
                    tmr_d     = tmr_q - 32'd1;
                    clk_idx_d = clk_idx_q + 16'd1;
                end
            end
            S_HBLANK: begin
                if (tmr_q == 32'd0) begin
                    state_d   = S_LINE;
                    tmr_d     = NCLK_M1;
                    line_d    = line_q + 16'd1;
                    clk_idx_d = 16'd0;
                end else begin
                    tmr_d = tmr_q - 32'd1;
                end
            end
            S_VBLANK: begin
                if (tmr_q == 32'd0) begin
                    // Abort only takes effect here, so a frame is never cut short.
                    if ((frame_cnt_q == req_q) || abort_q || abort) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        abort_d = 1'b0;
                    end else begin
                        state_d = S_SETUP;
                        tmr_d   = SETUP_M1;
                    end
                end else begin
                    tmr_d = tmr_q - 32'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next-state view so they align with the state.
        busy_d = (state_d != S_IDLE);
        fval_d = (state_d == S_SETUP) || (state_d == S_LINE) || (state_d == S_HBLANK);
        lval_d = (state_d == S_LINE);
        data_d = lval_d ? {frame_cnt_d[15:0], line_d, clk_idx_d, word_d} : 80'd0;
    end

    always_ff @(posedge cl_clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tmr_q       <= 32'd0;
            line_q      <= 16'd0;
            clk_idx_q   <= 16'd0;
            word_q      <= 32'd0;
            req_q       <= 20'd0;
            frame_cnt_q <= 20'd0;
            abort_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fval_q      <= 1'b0;
            lval_q      <= 1'b0;
            data_q      <= 80'd0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            line_q      <= line_d;
            clk_idx_q   <= clk_idx_d;
            word_q      <= word_d;
            req_q       <= req_d;
            frame_cnt_q <= frame_cnt_d;
            abort_q     <= abort_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fval_q      <= fval_d;
            lval_q      <= lval_d;
            data_q      <= data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign cl_fval   = fval_q;
    assign cl_lval   = lval_q;
    assign cl_data   = data_q;
    assign frame_cnt = frame_cnt_q;

endmodule
